// File: rtl/axi4_lite_write_master.sv
// AXI4-Lite write initiator: one command at a time, per-channel programmable valid delays,
// local DECERR for commands outside the address window, B response returned on a local port.
module axi4_lite_write_master #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              DELAY_WIDTH   = 5,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = 'h01,
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = 'hff
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_awaddr,
    input  logic [2:0]                cmd_awprot,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    input  logic [DELAY_WIDTH-1:0]    cmd_delay_aw,
    input  logic [DELAY_WIDTH-1:0]    cmd_delay_w,
    output logic [ADDRESS_WIDTH-1:0]  awaddr,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_bresp,
    output logic                      rsp_local,
    output logic [15:0]               wr_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, RESP} state_t;

    state_t                 state;
    logic [DELAY_WIDTH-1:0] aw_cnt;
    logic [DELAY_WIDTH-1:0] w_cnt;
    logic                   aw_done;
    logic                   w_done;
    logic                   aw_fin;
    logic                   w_fin;
    logic                   in_range;

    // A channel counts as finished in the cycle its handshake happens, so WAIT_B
    // follows the later handshake directly.
    always_comb begin
        in_range = (cmd_awaddr >= MIN_ADDRESS) && (cmd_awaddr <= MAX_ADDRESS);
        aw_fin   = aw_done || (awvalid && awready);
        w_fin    = w_done  || (wvalid && wready);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            aw_cnt    <= '0;
            w_cnt     <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cmd_ready <= 1'b1;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            rsp_valid <= 1'b0;
            awaddr    <= '0;
            awprot    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_bresp <= '0;
            rsp_local <= 1'b0;
            wr_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        awaddr    <= cmd_awaddr;
                        awprot    <= cmd_awprot;
                        wdata     <= cmd_wdata;
                        wstrb     <= cmd_wstrb;
                        cmd_ready <= 1'b0;
                        if (in_range) begin
                            state   <= ISSUE;
                            aw_cnt  <= cmd_delay_aw;
                            w_cnt   <= cmd_delay_w;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            awvalid <= (cmd_delay_aw == '0);
                            wvalid  <= (cmd_delay_w == '0);
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_bresp <= 2'b11;
                            rsp_local <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Valid is raised on the count 1 -> 0 step so it is visible the
                    // cycle the counter reads zero.
                    if (awvalid) begin
                        if (awready) begin
                            awvalid <= 1'b0;
                            aw_done <= 1'b1;
                        end
                    end else if (!aw_done && aw_cnt != '0) begin
                        aw_cnt <= aw_cnt - DELAY_WIDTH'(1);
                        if (aw_cnt == DELAY_WIDTH'(1)) awvalid <= 1'b1;
                    end
                    if (wvalid) begin
                        if (wready) begin
                            wvalid <= 1'b0;
                            w_done <= 1'b1;
                        end
                    end else if (!w_done && w_cnt != '0) begin
                        w_cnt <= w_cnt - DELAY_WIDTH'(1);
                        if (w_cnt == DELAY_WIDTH'(1)) wvalid <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state  <= WAIT_B;
                        bready <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (bvalid) begin
                        state     <= RESP;
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_bresp <= bresp;
                        rsp_local <= 1'b0;
                        wr_count  <= wr_count + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4_lite_write_master.md
# axi4_lite_write_master

Synthesizable AXI4-Lite write initiator: the master-side counterpart of the write slave VIP. It accepts one write command at a time from a local command port and issues it on the AW and W channels, each after its own programmable delay. It collects the B response and returns it on a local response port. Commands whose address is outside the configured window are rejected locally with DECERR and generate no bus traffic. The block drives DUT slaves in the AXI4-Lite environment and serves as the RTL reference initiator for slave verification.

## Interface
- ADDRESS_WIDTH, 32, AW address width (32 or 64)
- DATA_WIDTH, 32, W data width (32 or 64); strobe width is DATA_WIDTH/8
- DELAY_WIDTH, 5, width of per-channel valid-delay fields
- MIN_ADDRESS, 8'h01, lowest legal address, inclusive, zero-extended
- MAX_ADDRESS, 8'hff, highest legal address, inclusive, zero-extended
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_awaddr  in  ADDRESS_WIDTH  write address
- cmd_awprot  in  3  protection bits
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes
- cmd_delay_aw  in  DELAY_WIDTH  cycles before awvalid is asserted
- cmd_delay_w  in  DELAY_WIDTH  cycles before wvalid is asserted
- awaddr / awprot / awvalid  out  ADDRESS_WIDTH / 3 / 1  AW channel
- awready  in  1  AW channel
- wdata / wstrb / wvalid  out  DATA_WIDTH / DATA_WIDTH/8 / 1  W channel
- wready  in  1  W channel
- bresp / bvalid  in  2 / 1  B channel
- bready  out  1  B channel
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_bresp  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
- rsp_local  out  1  1 = response generated locally (address decode), not from the bus
- wr_count  out  16  completed bus writes; wraps at 16'hffff to 0

## Operation
- FSM states: IDLE, ISSUE, WAIT_B, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields.
  - Address in [MIN_ADDRESS, MAX_ADDRESS]: go to ISSUE and load aw_cnt=cmd_delay_aw, w_cnt=cmd_delay_w.
  - Address out of range: go to RESP with rsp_bresp=2'b11 and rsp_local=1.
- ISSUE: AW and W sub-channels are independent.
  - While a channel's counter is nonzero, decrement it.
  - When it reaches zero, assert that channel's valid and hold it until its ready is sampled high; the channel is then done and its valid deasserts the next cycle.
  - When both channels are done, go to WAIT_B.
- WAIT_B: bready=1. On bvalid, latch bresp, set rsp_local=0, increment wr_count, go to RESP.
- RESP: rsp_valid=1, and rsp_bresp/rsp_local are held stable. On rsp_ready, go to IDLE.
- Exactly one transaction is outstanding; cmd_ready=0 in all states except IDLE.
- awaddr/awprot/wdata/wstrb hold the latched values from acceptance until the next acceptance. They never change while their valid is high.

## Timing
- Reset: state=IDLE, all counters=0. Outputs cmd_ready=1, awvalid=wvalid=bready=rsp_valid=0, awaddr=awprot=wdata=wstrb=0, rsp_bresp=0, rsp_local=0, wr_count=0.
- Reset mid-transaction aborts immediately; no response is produced for the aborted command.
- Delay 0: valid is high in the first ISSUE cycle, i.e. the cycle after acceptance. Delay N: valid rises N cycles later.
- If ready is already high when valid rises, the handshake completes that cycle and valid is high for exactly one cycle.
- AW and W may complete in the same cycle or in either order.
- The cycle after the later of the two handshakes, the block is in WAIT_B with bready=1.
- A bvalid arriving before WAIT_B is ignored (bready=0); it is accepted once WAIT_B is entered.
- bvalid in the first WAIT_B cycle: RESP is entered the next cycle.
- Minimum bus-write latency, acceptance to rsp_valid, with zero delays and all readies high: 3 cycles.
- Local reject latency, acceptance to rsp_valid: 1 cycle.
- A rsp_ready sampled with rsp_valid returns the block to IDLE; the next command can be accepted in the cycle after the RESP handshake.

## Test plan
- Zero delays, awready/wready/bvalid tied high with bresp=00, addr=8'h10, data=32'hdeadbeef, strb=4'hf:
  - awvalid and wvalid each high 1 cycle in the same cycle;
  - rsp_valid 3 cycles after acceptance with rsp_bresp=00 and rsp_local=0;
  - wr_count=1.
- cmd_delay_aw=4, cmd_delay_w=0, awready high, wready held low 6 cycles:
  - wvalid rises 1 cycle after acceptance and stays high with stable wdata until wready;
  - awvalid rises 5 cycles after acceptance;
  - bready rises only after both handshakes.
- addr=8'h00 and then addr=8'h100:
  - each gives rsp_bresp=11 and rsp_local=1 one cycle after acceptance;
  - awvalid/wvalid never assert and wr_count is unchanged.
- Slave returns bresp=10 after 7 cycles of bvalid=0: rsp_bresp=10; rsp_valid held for 3 cycles while rsp_ready=0, with stable outputs.
- Assert areset while the block is in ISSUE with awvalid=1:
  - next cycle awvalid=0, cmd_ready=1, wr_count=0;
  - a new command then completes normally.
- Preload wr_count=16'hffff via 65535 writes (or force it), then complete one more write: wr_count=0.
